// File: rtl/csr_pkg.sv
// rtl/csr_pkg.sv - CSR addresses, write-op encodings, bit indices and WARL masks
package csr_pkg;

    localparam logic [11:0] A_MSTATUS   = 12'h300;
    localparam logic [11:0] A_MISA      = 12'h301;
    localparam logic [11:0] A_MIE       = 12'h304;
    localparam logic [11:0] A_MTVEC     = 12'h305;
    localparam logic [11:0] A_MSCRATCH  = 12'h340;
    localparam logic [11:0] A_MEPC      = 12'h341;
    localparam logic [11:0] A_MCAUSE    = 12'h342;
    localparam logic [11:0] A_MTVAL     = 12'h343;
    localparam logic [11:0] A_MIP       = 12'h344;
    localparam logic [11:0] A_MCYCLE    = 12'hB00;
    localparam logic [11:0] A_MCYCLEH   = 12'hB80;
    localparam logic [11:0] A_MINSTRET  = 12'hB02;
    localparam logic [11:0] A_MINSTRETH = 12'hB82;
    localparam logic [11:0] A_CYCLE     = 12'hC00;
    localparam logic [11:0] A_CYCLEH    = 12'hC80;
    localparam logic [11:0] A_INSTRET   = 12'hC02;
    localparam logic [11:0] A_INSTRETH  = 12'hC82;
    localparam logic [11:0] A_MHARTID   = 12'hF14;

    typedef enum logic [1:0] {
        WOP_WRITE = 2'b00,
        WOP_SET   = 2'b01,
        WOP_CLEAR = 2'b10,
        WOP_NONE  = 2'b11
    } wop_e;

    localparam int MIE_BIT  = 3;
    localparam int MPIE_BIT = 7;
    localparam int MSI_BIT  = 3;
    localparam int MTI_BIT  = 7;
    localparam int MEI_BIT  = 11;

    localparam logic [31:0] MSTATUS_MPP  = 32'h0000_1800;
    localparam logic [31:0] MSTATUS_MASK = 32'h0000_0088;
    localparam logic [31:0] MIE_MASK     = 32'h0000_0888;
    localparam logic [31:0] MTVEC_MASK   = 32'hFFFF_FFFD;
    localparam logic [31:0] MEPC_MASK    = 32'hFFFF_FFFC;

    function automatic logic [31:0] apply_op(input wop_e op, input logic [31:0] old,
                                             input logic [31:0] d);
        case (op)
            WOP_WRITE: return d;
            WOP_SET:   return old | d;
            WOP_CLEAR: return old & ~d;
            default:   return old;
        endcase
    endfunction

endpackage

// File: rtl/csr_counter.sv
// rtl/csr_counter.sv - W-bit free-running counter with 32-bit lo/hi write and read ports
module csr_counter #(
    parameter int W = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inc_i,
    input  logic        we_lo_i,
    input  logic        we_hi_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] lo_o,
    output logic [31:0] hi_o
);

    logic [W-1:0] cnt;

    // A half write replaces that half and suppresses the increment for the cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (we_lo_i) begin
            cnt <= {cnt[W-1:32], wdata_i};
        end else if (we_hi_i) begin
            cnt <= {wdata_i[W-33:0], cnt[31:0]};
        end else if (inc_i) begin
            cnt <= cnt + {{(W-1){1'b0}}, 1'b1};
        end
    end

    assign lo_o = cnt[31:0];
    assign hi_o = 32'(cnt[W-1:32]);

endmodule

// File: rtl/csr_unit.sv
// rtl/csr_unit.sv - machine-mode CSR file with trap/mret stacking, RMW writes, mip and counters
module csr_unit
    import csr_pkg::*;
#(
    parameter int          CNT_WIDTH = 64,
    parameter logic [31:0] HART_ID   = 32'h0,
    parameter logic [31:0] MTVEC_RST = 32'h0000_0000,
    parameter logic [31:0] MISA_VAL  = 32'h4000_0100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] raddr_i,
    output logic [31:0] rdata_o,
    output logic        rillegal_o,
    input  logic        we_i,
    input  logic [11:0] waddr_i,
    input  logic [1:0]  wop_i,
    input  logic [31:0] wdata_i,
    output logic        willegal_o,
    input  logic        trap_i,
    input  logic [31:0] trap_cause_i,
    input  logic [31:0] trap_pc_i,
    input  logic [31:0] trap_val_i,
    input  logic        mret_i,
    input  logic        retire_i,
    input  logic        irq_ext_i,
    input  logic        irq_tmr_i,
    input  logic        irq_sw_i,
    output logic [31:0] mtvec_o,
    output logic [31:0] mepc_o,
    output logic        irq_pending_o
);

    logic        mie_en, mpie;
    logic [31:0] mie_r, mtvec_r, mscratch_r, mepc_r, mcause_r, mtval_r;
    logic [2:0]  mip_r;
    logic [31:0] mstatus_val, mip_val;
    logic [31:0] cyc_lo, cyc_hi, ins_lo, ins_hi;
    logic [32:0] rd_res, wr_old;
    logic [31:0] wraw, wnew;
    logic        writable, wr_en;

    assign mstatus_val = MSTATUS_MPP | (32'(mpie) << MPIE_BIT) | (32'(mie_en) << MIE_BIT);
    assign mip_val     = (32'(mip_r[2]) << MEI_BIT) | (32'(mip_r[1]) << MTI_BIT)
                       | (32'(mip_r[0]) << MSI_BIT);

    // Returns {implemented, value} for an address.
    function automatic logic [32:0] csr_read(input logic [11:0] a);
        case (a)
            A_MSTATUS:              return {1'b1, mstatus_val};
            A_MISA:                 return {1'b1, MISA_VAL};
            A_MIE:                  return {1'b1, mie_r};
            A_MTVEC:                return {1'b1, mtvec_r};
            A_MSCRATCH:             return {1'b1, mscratch_r};
            A_MEPC:                 return {1'b1, mepc_r};
            A_MCAUSE:               return {1'b1, mcause_r};
            A_MTVAL:                return {1'b1, mtval_r};
            A_MIP:                  return {1'b1, mip_val};
            A_MCYCLE, A_CYCLE:      return {1'b1, cyc_lo};
            A_MCYCLEH, A_CYCLEH:    return {1'b1, cyc_hi};
            A_MINSTRET, A_INSTRET:  return {1'b1, ins_lo};
            A_MINSTRETH, A_INSTRETH: return {1'b1, ins_hi};
            A_MHARTID:              return {1'b1, HART_ID};
            default:                return 33'h0;
        endcase
    endfunction

    always_comb begin
        writable = 1'b0;
        wr_old   = csr_read(waddr_i);
        wraw     = apply_op(wop_e'(wop_i), wr_old[31:0], wdata_i);
        wnew     = wraw;
        case (waddr_i)
            A_MSTATUS: begin writable = 1'b1; wnew = MSTATUS_MPP | (wraw & MSTATUS_MASK); end
            A_MIE:     begin writable = 1'b1; wnew = wraw & MIE_MASK; end
            A_MTVEC:   begin writable = 1'b1; wnew = wraw & MTVEC_MASK; end
            A_MEPC:    begin writable = 1'b1; wnew = wraw & MEPC_MASK; end
            A_MIP:     begin writable = 1'b1; wnew = wr_old[31:0]; end
            A_MSCRATCH, A_MCAUSE, A_MTVAL,
            A_MCYCLE, A_MCYCLEH, A_MINSTRET, A_MINSTRETH: writable = 1'b1;
            default: ;
        endcase
    end

    assign willegal_o = we_i & ~writable;
    assign wr_en      = we_i & writable & (wop_i != WOP_NONE) & ~trap_i & ~mret_i;

    always_comb begin
        rd_res     = csr_read(raddr_i);
        rillegal_o = ~rd_res[32];
        rdata_o    = (wr_en && waddr_i == raddr_i) ? wnew : rd_res[31:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mie_en     <= 1'b0;
            mpie       <= 1'b0;
            mie_r      <= '0;
            mtvec_r    <= MTVEC_RST;
            mscratch_r <= '0;
            mepc_r     <= '0;
            mcause_r   <= '0;
            mtval_r    <= '0;
            mip_r      <= '0;
        end else begin
            mip_r <= {irq_ext_i, irq_tmr_i, irq_sw_i};
            if (trap_i) begin
                mepc_r   <= trap_pc_i & MEPC_MASK;
                mcause_r <= trap_cause_i;
                mtval_r  <= trap_val_i;
                mpie     <= mie_en;
                mie_en   <= 1'b0;
            end else if (mret_i) begin
                mie_en <= mpie;
                mpie   <= 1'b1;
            end else if (wr_en) begin
                case (waddr_i)
                    A_MSTATUS: begin
                        mie_en <= wnew[MIE_BIT];
                        mpie   <= wnew[MPIE_BIT];
                    end
                    A_MIE:      mie_r      <= wnew;
                    A_MTVEC:    mtvec_r    <= wnew;
                    A_MSCRATCH: mscratch_r <= wnew;
                    A_MEPC:     mepc_r     <= wnew;
                    A_MCAUSE:   mcause_r   <= wnew;
                    A_MTVAL:    mtval_r    <= wnew;
                    default: ;
                endcase
            end
        end
    end

    csr_counter #(.W(CNT_WIDTH)) u_mcycle (
        .clk(clk), .rst(rst), .inc_i(1'b1),
        .we_lo_i(wr_en && waddr_i == A_MCYCLE), .we_hi_i(wr_en && waddr_i == A_MCYCLEH),
        .wdata_i(wnew), .lo_o(cyc_lo), .hi_o(cyc_hi)
    );

    csr_counter #(.W(CNT_WIDTH)) u_minstret (
        .clk(clk), .rst(rst), .inc_i(retire_i),
        .we_lo_i(wr_en && waddr_i == A_MINSTRET), .we_hi_i(wr_en && waddr_i == A_MINSTRETH),
        .wdata_i(wnew), .lo_o(ins_lo), .hi_o(ins_hi)
    );

    assign mtvec_o       = mtvec_r;
    assign mepc_o        = mepc_r;
    assign irq_pending_o = mie_en & |(mie_r & mip_val);

endmodule
